prefetch_unit: RTL and testbench

Parametrised successor to the combinational fetch stage of the 6502 core. Runs ahead of decode, issuing pipelined byte-beat reads to instruction memory and buffering returned bytes in a circular byte queue. Presents one complete variable-length 6502 instruction (opcode plus 0–2 operand bytes) per handshake to ID. Supports PC redirect with flush and discard of in-flight responses.

---
 rtl/prefetch_unit.sv | 146 ++++++++++++++
 tb/tb_prefetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - 6502 instruction prefetch queue with pipelined byte-beat fetch and redirect flush
module prefetch_unit #(
  parameter int                       MEM_ADDR_SIZE   = 16,
  parameter int                       BEAT_BYTES      = 1,
  parameter int                       QUEUE_BYTES     = 8,
  parameter int                       MAX_OUTSTANDING = 2,
  parameter logic [MEM_ADDR_SIZE-1:0] RESET_ADDR      = 'h8000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [MEM_ADDR_SIZE-1:0]   redirect_addr_i,
  output logic                       mem_req_o,
  output logic [MEM_ADDR_SIZE-1:0]   mem_addr_o,
  input  logic                       mem_ready_i,
  input  logic                       mem_rvalid_i,
  input  logic [8*BEAT_BYTES-1:0]    mem_rdata_i,
  output logic                       instr_valid_o,
  output logic [7:0]                 instr_o,
  output logic [15:0]                data_o,
  output logic [1:0]                 instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0]   instr_pc_o,
  input  logic                       id_ready_i
);

  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  localparam int OW = 3;

  // Instruction length from the 6502 opcode map (aaabbbcc layout); undefined opcodes are 1 byte.
  function automatic logic [1:0] opcode_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] len;
    bbb = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
        else if (op != 8'h89) len = 2'd2;
      end
      2'b10: begin
        if (bbb == 3'b001 || bbb == 3'b101 || op == 8'hA2) len = 2'd2;
        else if (bbb == 3'b011 || (bbb == 3'b111 && op != 8'h9E)) len = 2'd3;
      end
      2'b00: begin
        if (bbb == 3'b100) len = 2'd2;
        else if (op == 8'h20 || op == 8'hBC || (bbb == 3'b011 && op != 8'h0C)) len = 2'd3;
        else if (op inside {8'hA0, 8'hC0, 8'hE0, 8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4, 8'h94, 8'hB4})
          len = 2'd2;
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  logic [7:0]               queue_mem [QUEUE_BYTES];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [OW-1:0]            outstanding;
  logic [OW-1:0]            drop_cnt;
  logic [MEM_ADDR_SIZE-1:0] fetch_addr;
  logic [MEM_ADDR_SIZE-1:0] head_pc;

  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [7:0]  byte2;
  logic [31:0] free_bytes;
  logic [31:0] need_bytes;
  logic        accept;
  logic        write_en;
  logic        pop_en;
  logic [CW-1:0] written;
  logic [CW-1:0] popped;
  logic [OW-1:0] accept_inc;
  logic [OW-1:0] rvalid_dec;

  assign byte0 = queue_mem[rd_ptr];
  assign byte1 = queue_mem[rd_ptr + PW'(1)];
  assign byte2 = queue_mem[rd_ptr + PW'(2)];

  assign instr_o       = byte0;
  assign instr_len_o   = opcode_len(byte0);
  assign data_o        = {(instr_len_o == 2'd3) ? byte2 : 8'h00,
                          (instr_len_o >= 2'd2) ? byte1 : 8'h00};
  assign instr_valid_o = (count != '0) && (count >= CW'(instr_len_o));
  assign instr_pc_o    = head_pc;
  assign mem_addr_o    = fetch_addr;

  // Space is reserved for every in-flight beat, so a response can always be written.
  assign free_bytes = 32'(QUEUE_BYTES) - 32'(count);
  assign need_bytes = (32'(outstanding) + 32'd1) * 32'(BEAT_BYTES);
  assign mem_req_o  = !rst_i && !redirect_i &&
                      (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                      (free_bytes >= need_bytes);

  assign accept     = mem_req_o && mem_ready_i;
  assign write_en   = !rst_i && !redirect_i && mem_rvalid_i && (drop_cnt == '0);
  assign pop_en     = !rst_i && !redirect_i && instr_valid_o && id_ready_i;
  assign written    = write_en ? CW'(BEAT_BYTES) : '0;
  assign popped     = pop_en ? CW'(instr_len_o) : '0;
  assign accept_inc = {{(OW-1){1'b0}}, accept};
  assign rvalid_dec = {{(OW-1){1'b0}}, mem_rvalid_i};

  // Byte storage: each accepted beat lands little-endian starting at the write pointer.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        queue_mem[wr_ptr + PW'(k)] <= mem_rdata_i[8*k +: 8];
      end
    end
  end

  // Queue pointers, occupancy, request tracking and PCs; redirect flushes and marks in-flight beats stale.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_addr  <= RESET_ADDR;
      head_pc     <= RESET_ADDR;
    end else begin
      outstanding <= outstanding + accept_inc - rvalid_dec;
      if (redirect_i) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        drop_cnt   <= outstanding - rvalid_dec;
        fetch_addr <= redirect_addr_i;
        head_pc    <= redirect_addr_i;
      end else begin
        if (accept) fetch_addr <= fetch_addr + MEM_ADDR_SIZE'(BEAT_BYTES);
        if (mem_rvalid_i && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (write_en) wr_ptr <= wr_ptr + PW'(BEAT_BYTES);
        if (pop_en) begin
          rd_ptr  <= rd_ptr + PW'(instr_len_o);
          head_pc <= head_pc + MEM_ADDR_SIZE'(instr_len_o);
        end
        count <= count + written - popped;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - directed self-checking bench for prefetch_unit
module tb_prefetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_ready;
  logic        id_ready;

  logic        req_a, rvalid_a, valid_a;
  logic [15:0] addr_a, data_a, pc_a;
  logic [7:0]  rdata_a, instr_a;
  logic [1:0]  len_a;

  logic        req_b, rvalid_b, valid_b;
  logic [15:0] addr_b, data_b, pc_b, rdata_b;
  logic [7:0]  instr_b;
  logic [1:0]  len_b;

  prefetch_unit #(
    .MEM_ADDR_SIZE(16), .BEAT_BYTES(1), .QUEUE_BYTES(8), .MAX_OUTSTANDING(2), .RESET_ADDR(16'h8000)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .mem_req_o(req_a), .mem_addr_o(addr_a), .mem_ready_i(mem_ready),
    .mem_rvalid_i(rvalid_a), .mem_rdata_i(rdata_a),
    .instr_valid_o(valid_a), .instr_o(instr_a), .data_o(data_a), .instr_len_o(len_a),
    .instr_pc_o(pc_a), .id_ready_i(id_ready)
  );

  prefetch_unit #(
    .MEM_ADDR_SIZE(16), .BEAT_BYTES(2), .QUEUE_BYTES(8), .MAX_OUTSTANDING(2), .RESET_ADDR(16'hFFFE)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .mem_req_o(req_b), .mem_addr_o(addr_b), .mem_ready_i(mem_ready),
    .mem_rvalid_i(rvalid_b), .mem_rdata_i(rdata_b),
    .instr_valid_o(valid_b), .instr_o(instr_b), .data_o(data_b), .instr_len_o(len_b),
    .instr_pc_o(pc_b), .id_ready_i(id_ready)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [15:0] data;
    logic [1:0]  len;
    int          cyc;
  } log_t;

  logic [7:0]  mem [0:65535];
  pend_t       pend_a[$];
  pend_t       pend_b[$];
  logic [15:0] acc_a[$];
  logic [15:0] acc_b[$];
  log_t        log_a[$];
  log_t        log_b[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int lat      = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ent(input string tag, input log_t q[$], input int idx,
                           input logic [15:0] pc, input logic [7:0] op,
                           input logic [1:0] len, input logic [15:0] data);
    check({tag, "_present"}, 32'(q.size() > idx), 1);
    if (q.size() > idx) begin
      check({tag, "_pc"},   q[idx].pc,   pc);
      check({tag, "_op"},   q[idx].op,   op);
      check({tag, "_len"},  q[idx].len,  len);
      check({tag, "_data"}, q[idx].data, data);
    end
  endtask

  // One cycle: drive due responses, observe handshakes mid-cycle, advance past the edge.
  task automatic step();
    pend_t p;
    rvalid_a = 1'b0; rdata_a = 8'h00;
    rvalid_b = 1'b0; rdata_b = 16'h0000;
    if (pend_a.size() > 0 && pend_a[0].due <= cyc) begin
      p = pend_a.pop_front();
      rvalid_a = 1'b1;
      rdata_a  = mem[p.addr];
    end
    if (pend_b.size() > 0 && pend_b[0].due <= cyc) begin
      p = pend_b.pop_front();
      rvalid_b = 1'b1;
      rdata_b  = {mem[p.addr + 16'd1], mem[p.addr]};
    end
    #1;
    if (req_a && mem_ready) begin
      pend_a.push_back('{addr: addr_a, due: cyc + lat});
      acc_a.push_back(addr_a);
    end
    if (req_b && mem_ready) begin
      pend_b.push_back('{addr: addr_b, due: cyc + lat});
      acc_b.push_back(addr_b);
    end
    if (valid_a && id_ready)
      log_a.push_back('{pc: pc_a, op: instr_a, data: data_a, len: len_a, cyc: cyc - base});
    if (valid_b && id_ready)
      log_b.push_back('{pc: pc_b, op: instr_b, data: data_b, len: len_b, cyc: cyc - base});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    redirect = 1'b0;
    pend_a.delete();
    pend_b.delete();
    step();
    step();
    check({tag, "_req"},   req_a, 0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_pc_a"},  pc_a, 16'h8000);
    check({tag, "_pc_b"},  pc_b, 16'hFFFE);
    acc_a.delete(); acc_b.delete();
    log_a.delete(); log_b.delete();
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h05;
    mem[16'h8003] = 8'hAD; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
    mem[16'h8006] = 8'hA2; mem[16'h8007] = 8'h77;
    mem[16'hC000] = 8'hAD; mem[16'hC001] = 8'h78; mem[16'hC002] = 8'h56;
    mem[16'hD000] = 8'hAD; mem[16'hD001] = 8'h34; mem[16'hD002] = 8'h12;
    mem[16'hFFFE] = 8'hEA; mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h05;

    rst = 1'b1; redirect = 1'b0; redirect_addr = 16'h0000;
    mem_ready = 1'b1; id_ready = 1'b1;
    rvalid_a = 1'b0; rdata_a = 8'h00; rvalid_b = 1'b0; rdata_b = 16'h0000;
    #1;

    // Zero-wait stream from reset; BEAT_BYTES=2 instance wraps past FFFF in parallel.
    lat = 1;
    do_reset("rst0");
    repeat (12) step();
    check_ent("t1_i0", log_a, 0, 16'h8000, 8'hEA, 2'd1, 16'h0000);
    check_ent("t1_i1", log_a, 1, 16'h8001, 8'hA9, 2'd2, 16'h0005);
    check_ent("t1_i2", log_a, 2, 16'h8003, 8'hAD, 2'd3, 16'h1234);
    if (log_a.size() >= 3) begin
      check("t1_first_cyc", log_a[0].cyc, 2);
      check("t1_second_cyc", log_a[1].cyc, 4);
      check("t1_third_cyc", log_a[2].cyc, 7);
    end
    check("t1_b_accepts", 32'(acc_b.size() >= 2), 1);
    if (acc_b.size() >= 2) begin
      check("t1_b_addr0", acc_b[0], 16'hFFFE);
      check("t1_b_addr1", acc_b[1], 16'h0000);
    end
    check_ent("t1_b_i0", log_b, 0, 16'hFFFE, 8'hEA, 2'd1, 16'h0000);
    check_ent("t1_b_i1", log_b, 1, 16'hFFFF, 8'hA9, 2'd2, 16'h0005);
    check_ent("t1_b_i2", log_b, 2, 16'h0001, 8'hEA, 2'd1, 16'h0000);

    // Backpressure: requests stop once queue plus in-flight reach 8 bytes; nothing lost on resume.
    id_ready = 1'b0;
    do_reset("rst1");
    repeat (15) step();
    check("t2_accepts", acc_a.size(), 8);
    check("t2_req_stalled", req_a, 0);
    check("t2_head_valid", valid_a, 1);
    if (acc_a.size() >= 8) check("t2_last_addr", acc_a[7], 16'h8007);
    id_ready = 1'b1;
    repeat (14) step();
    check_ent("t2_i0", log_a, 0, 16'h8000, 8'hEA, 2'd1, 16'h0000);
    check_ent("t2_i1", log_a, 1, 16'h8001, 8'hA9, 2'd2, 16'h0005);
    check_ent("t2_i2", log_a, 2, 16'h8003, 8'hAD, 2'd3, 16'h1234);
    check_ent("t2_i3", log_a, 3, 16'h8006, 8'hA2, 2'd2, 16'h0077);
    check_ent("t2_i4", log_a, 4, 16'h8008, 8'hEA, 2'd1, 16'h0000);

    // Redirect with two slow requests in flight: both stale beats are dropped.
    lat = 3;
    id_ready = 1'b1;
    do_reset("rst2");
    step();
    step();
    redirect = 1'b1;
    redirect_addr = 16'hC000;
    step();
    redirect = 1'b0;
    check("t3_valid_after_redir", valid_a, 0);
    check("t3_fetch_addr", addr_a, 16'hC000);
    repeat (15) step();
    check("t3_accepts", 32'(acc_a.size() > 2), 1);
    if (acc_a.size() > 2) check("t3_first_new_addr", acc_a[2], 16'hC000);
    check_ent("t3_i0", log_a, 0, 16'hC000, 8'hAD, 2'd3, 16'h5678);

    // Three-byte opcode with its last operand held back by the memory.
    lat = 1;
    id_ready = 1'b0;
    do_reset("rst3");
    redirect = 1'b1;
    redirect_addr = 16'hD000;
    step();
    redirect = 1'b0;
    step();
    step();
    mem_ready = 1'b0;
    repeat (2) step();
    check("t4_partial_a", valid_a, 0);
    repeat (3) step();
    check("t4_partial_b", valid_a, 0);
    mem_ready = 1'b1;
    step();
    check("t4_in_flight", valid_a, 0);
    step();
    check("t4_valid", valid_a, 1);
    check("t4_op", instr_a, 8'hAD);
    check("t4_len", len_a, 2'd3);
    check("t4_data", data_a, 16'h1234);
    check("t4_pc", pc_a, 16'hD000);

    // Reset in mid-stream with bytes queued.
    lat = 1;
    id_ready = 1'b0;
    do_reset("rst4");
    repeat (5) step();
    check("t6_prefill_valid", valid_a, 1);
    rst = 1'b1;
    pend_a.delete();
    pend_b.delete();
    step();
    check("t6_rst_valid", valid_a, 0);
    check("t6_rst_req", req_a, 0);
    check("t6_rst_pc", pc_a, 16'h8000);
    rst = 1'b0;
    #1;
    check("t6_post_valid", valid_a, 0);
    check("t6_post_req", req_a, 1);
    check("t6_post_addr", addr_a, 16'h8000);
    check("t6_post_pc", pc_a, 16'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
